// File: rtl/mem_lsu_pkg.sv
// Shared constants, state encoding and size helpers for the MEM-stage load/store unit.
package mem_lsu_pkg;

   localparam int unsigned XLEN = 32;
   localparam int unsigned NB   = 4;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic {
      IDLE  = 1'b0,
      SPLIT = 1'b1
   } state_e;

   // Right-aligned byte mask of the access width; zero for funct3 codes with no width.
   function automatic logic [NB-1:0] size_mask(input logic [2:0] funct3);
      case (funct3)
         F3_B, F3_BU: size_mask = 4'b0001;
         F3_H, F3_HU: size_mask = 4'b0011;
         F3_W:        size_mask = 4'b1111;
         default:     size_mask = 4'b0000;
      endcase
   endfunction

   function automatic logic [2:0] size_bytes(input logic [2:0] funct3);
      case (funct3[1:0])
         2'b00:   size_bytes = 3'd1;
         2'b01:   size_bytes = 3'd2;
         default: size_bytes = 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane alignment for the load/store unit: store-lane shift, byte enables,
// load extraction, two-word merge and sign/zero extension.
module lsu_align
   import mem_lsu_pkg::*;
(
   input  logic            second,
   input  logic [1:0]      off,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] wdata,
   input  logic [XLEN-1:0] rd_data,
   input  logic [XLEN-1:0] lo,
   output logic [NB-1:0]   be_c,
   output logic [XLEN-1:0] wd_c,
   output logic [XLEN-1:0] lo_c,
   output logic [XLEN-1:0] ld_c
);

   logic [NB-1:0]   mask;
   logic [5:0]      sh_lo;
   logic [5:0]      sh_hi;
   logic [XLEN-1:0] raw;

   // The second word of a split carries the bytes that spilled past the first word.
   always_comb begin
      mask  = size_mask(funct3);
      sh_lo = {1'b0, off, 3'b000};
      sh_hi = 6'd32 - sh_lo;
      lo_c  = rd_data >> sh_lo;
      if (second) begin
         be_c = mask >> (3'd4 - {1'b0, off});
         wd_c = wdata >> sh_hi;
         raw  = lo | (rd_data << sh_hi);
      end else begin
         be_c = mask << off;
         wd_c = wdata << sh_lo;
         raw  = lo_c;
      end
      case (funct3)
         F3_B:    ld_c = {{24{raw[7]}}, raw[7:0]};
         F3_H:    ld_c = {{16{raw[15]}}, raw[15:0]};
         F3_W:    ld_c = raw;
         F3_BU:   ld_c = {24'd0, raw[7:0]};
         F3_HU:   ld_c = {16'd0, raw[15:0]};
         default: ld_c = '0;
      endcase
   end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: drives the data memory, splits word-crossing
// accesses over two cycles and registers the extended result toward WB.
module mem_lsu
   import mem_lsu_pkg::*;
#(
   parameter bit ALLOW_MISALIGNED = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_wdata,
   input  logic            req_we,
   input  logic [2:0]      req_funct3,
   input  logic [4:0]      req_rd,
   output logic [XLEN-1:0] dm_addr,
   output logic [XLEN-1:0] dm_wd,
   output logic [NB-1:0]   dm_be,
   output logic            dm_we,
   input  logic [XLEN-1:0] dm_rd,
   output logic            resp_valid,
   output logic [XLEN-1:0] resp_data,
   output logic [4:0]      resp_rd,
   output logic            resp_fault
);

   state_e          state_q, state_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic [XLEN-1:0] wdata_q, wdata_d;
   logic [XLEN-1:0] lo_q, lo_d;
   logic [2:0]      funct3_q, funct3_d;
   logic [4:0]      rd_q, rd_d;
   logic            we_q, we_d;
   logic            resp_valid_q, resp_valid_d;
   logic [XLEN-1:0] resp_data_q, resp_data_d;
   logic [4:0]      resp_rd_q, resp_rd_d;
   logic            resp_fault_q, resp_fault_d;

   logic            fire;
   logic            illegal;
   logic            misaligned;
   logic            crossing;
   logic            fault;
   logic [2:0]      size;
   logic [3:0]      span;

   logic            al_second;
   logic [1:0]      al_off;
   logic [2:0]      al_f3;
   logic [XLEN-1:0] al_wdata;
   logic [NB-1:0]   al_be;
   logic [XLEN-1:0] al_wd;
   logic [XLEN-1:0] al_lo;
   logic [XLEN-1:0] al_ld;

   assign req_ready  = (state_q == IDLE);
   assign fire       = req_valid && req_ready && rst_n;
   assign resp_valid = resp_valid_q;
   assign resp_data  = resp_data_q;
   assign resp_rd    = resp_rd_q;
   assign resp_fault = resp_fault_q;

   // Request decode: legality, natural alignment and word crossing.
   always_comb begin
      size = size_bytes(req_funct3);
      if (req_we) begin
         illegal = !(req_funct3 inside {F3_B, F3_H, F3_W});
      end else begin
         illegal = req_funct3 inside {3'b011, 3'b110, 3'b111};
      end
      misaligned = ((size == 3'd2) && req_addr[0]) ||
                   ((size == 3'd4) && (req_addr[1:0] != 2'b00));
      span       = 4'(req_addr[1:0]) + 4'(size);
      crossing   = (span > 4'd4);
      fault      = illegal || (misaligned && !ALLOW_MISALIGNED);
   end

   // Aligner sees the live request in IDLE and the latched one in SPLIT.
   always_comb begin
      al_second = 1'b0;
      al_off    = req_addr[1:0];
      al_f3     = req_funct3;
      al_wdata  = req_wdata;
      if (state_q == SPLIT) begin
         al_second = 1'b1;
         al_off    = addr_q[1:0];
         al_f3     = funct3_q;
         al_wdata  = wdata_q;
      end
   end

   lsu_align u_align (
      .second  (al_second),
      .off     (al_off),
      .funct3  (al_f3),
      .wdata   (al_wdata),
      .rd_data (dm_rd),
      .lo      (lo_q),
      .be_c    (al_be),
      .wd_c    (al_wd),
      .lo_c    (al_lo),
      .ld_c    (al_ld)
   );

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      lo_d         = lo_q;
      funct3_d     = funct3_q;
      rd_d         = rd_q;
      we_d         = we_q;
      resp_valid_d = 1'b0;
      resp_data_d  = resp_data_q;
      resp_rd_d    = resp_rd_q;
      resp_fault_d = resp_fault_q;
      dm_addr      = {req_addr[XLEN-1:2], 2'b00};
      dm_wd        = al_wd;
      dm_be        = '0;
      dm_we        = 1'b0;

      case (state_q)
         IDLE: begin
            if (fire) begin
               if (fault) begin
                  resp_valid_d = 1'b1;
                  resp_fault_d = 1'b1;
                  resp_data_d  = '0;
                  resp_rd_d    = req_rd;
               end else begin
                  dm_be = al_be;
                  dm_we = req_we;
                  if (crossing) begin
                     addr_d   = req_addr;
                     wdata_d  = req_wdata;
                     funct3_d = req_funct3;
                     rd_d     = req_rd;
                     we_d     = req_we;
                     lo_d     = al_lo;
                     state_d  = SPLIT;
                  end else begin
                     resp_valid_d = 1'b1;
                     resp_fault_d = 1'b0;
                     resp_data_d  = req_we ? '0 : al_ld;
                     resp_rd_d    = req_rd;
                  end
               end
            end
         end
         SPLIT: begin
            dm_addr      = {addr_q[XLEN-1:2], 2'b00} + 32'd4;
            dm_be        = al_be;
            dm_we        = we_q && rst_n;
            resp_valid_d = 1'b1;
            resp_fault_d = 1'b0;
            resp_data_d  = we_q ? '0 : al_ld;
            resp_rd_d    = rd_q;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         wdata_q      <= '0;
         lo_q         <= '0;
         funct3_q     <= '0;
         rd_q         <= '0;
         we_q         <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
         resp_rd_q    <= '0;
         resp_fault_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         lo_q         <= lo_d;
         funct3_q     <= funct3_d;
         rd_q         <= rd_d;
         we_q         <= we_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
         resp_rd_q    <= resp_rd_d;
         resp_fault_q <= resp_fault_d;
      end
   end

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed scenarios plus random traffic
// checked against a byte-addressed memory model.
module tb_mem_lsu;
   import mem_lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_we;
   logic [31:0] req_addr, req_wdata;
   logic [2:0]  req_funct3;
   logic [4:0]  req_rd;

   logic        req_ready, dm_we, resp_valid, resp_fault;
   logic [31:0] dm_addr, dm_wd, dm_rd, resp_data;
   logic [3:0]  dm_be;
   logic [4:0]  resp_rd;

   logic        req_ready0, dm_we0, resp_valid0, resp_fault0;
   logic [31:0] dm_addr0, dm_wd0, dm_rd0, resp_data0;
   logic [3:0]  dm_be0;
   logic [4:0]  resp_rd0;

   logic [31:0] mem  [64] = '{default: '0};
   logic [31:0] mem0 [64] = '{default: '0};
   logic [7:0]  ref_mem [256] = '{default: '0};

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mem_lsu #(.ALLOW_MISALIGNED(1'b1)) u_dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_we(req_we), .req_funct3(req_funct3),
      .req_rd(req_rd), .dm_addr(dm_addr), .dm_wd(dm_wd), .dm_be(dm_be), .dm_we(dm_we),
      .dm_rd(dm_rd), .resp_valid(resp_valid), .resp_data(resp_data), .resp_rd(resp_rd),
      .resp_fault(resp_fault));

   mem_lsu #(.ALLOW_MISALIGNED(1'b0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready0),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_we(req_we), .req_funct3(req_funct3),
      .req_rd(req_rd), .dm_addr(dm_addr0), .dm_wd(dm_wd0), .dm_be(dm_be0), .dm_we(dm_we0),
      .dm_rd(dm_rd0), .resp_valid(resp_valid0), .resp_data(resp_data0), .resp_rd(resp_rd0),
      .resp_fault(resp_fault0));

   assign dm_rd  = mem[dm_addr[7:2]];
   assign dm_rd0 = mem0[dm_addr0[7:2]];

   always @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (dm_we && dm_be[b])   mem[dm_addr[7:2]][8*b +: 8]   <= dm_wd[8*b +: 8];
         if (dm_we0 && dm_be0[b]) mem0[dm_addr0[7:2]][8*b +: 8] <= dm_wd0[8*b +: 8];
      end
   end

   // Reference model: a flat byte memory, accesses gathered byte by byte.
   function automatic int unsigned sz(input logic [2:0] f3);
      return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
   endfunction

   function automatic bit is_fault(input bit we, input logic [2:0] f3, input logic [31:0] a,
                                   input bit allow);
      bit ill, mis;
      int unsigned s;
      s   = sz(f3);
      ill = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
      mis = (s == 2 && a[0]) || (s == 4 && a[1:0] != 2'b00);
      return ill || (mis && !allow);
   endfunction

   function automatic bit is_split(input bit we, input logic [2:0] f3, input logic [31:0] a);
      return !is_fault(we, f3, a, 1'b1) && ((32'(a[1:0]) + sz(f3)) > 4);
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
      logic [31:0] v;
      int unsigned s;
      s = sz(f3);
      v = '0;
      for (int i = 0; i < int'(s); i++) v = v | (32'(ref_mem[8'(a + 32'(i))]) << (8*i));
      if (!f3[2] && s < 4 && v[8*s-1]) v = v | ~((32'd1 << (8*s)) - 32'd1);
      return v;
   endfunction

   task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
      for (int i = 0; i < int'(sz(f3)); i++) ref_mem[8'(a + 32'(i))] = wd[8*i +: 8];
   endtask

   task automatic drive(input bit we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [4:0] rd);
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_rd = rd;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0; req_rd = '0;
      repeat (2) @(negedge clk);
      drive(1'b1, F3_W, 32'h40, 32'h12345678, 5'd1);
      #1;
      checks++; if (dm_we !== 1'b0) begin errors++; $display("FAIL reset_dm_we got=%b exp=0", dm_we); end
      checks++; if (req_ready !== 1'b1 || req_ready0 !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b/%b exp=1", req_ready, req_ready0); end
      checks++; if ({resp_valid, resp_fault, resp_rd, resp_data} !== 39'd0) begin errors++; $display("FAIL reset_resp got v=%b f=%b rd=%0d d=%h exp=0", resp_valid, resp_fault, resp_rd, resp_data); end
      @(negedge clk);
      req_valid = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_no_resp got=%b exp=0", resp_valid); end
   endtask

   task automatic test_store_word();
      @(negedge clk);
      drive(1'b1, F3_W, 32'h10, 32'hDEADBEEF, 5'd4);
      ref_store(F3_W, 32'h10, 32'hDEADBEEF);
      #1;
      checks++; if (dm_addr !== 32'h10 || dm_be !== 4'b1111 || dm_wd !== 32'hDEADBEEF || dm_we !== 1'b1) begin errors++; $display("FAIL sw_drive got a=%h be=%b wd=%h we=%b exp a=10 be=1111 wd=deadbeef we=1", dm_addr, dm_be, dm_wd, dm_we); end
      @(negedge clk);
      req_valid = 1'b0;
      checks++; if (resp_valid !== 1'b1 || resp_fault !== 1'b0 || resp_data !== 32'h0 || resp_rd !== 5'd4) begin errors++; $display("FAIL sw_resp got v=%b f=%b d=%h rd=%0d exp v=1 f=0 d=0 rd=4", resp_valid, resp_fault, resp_data, resp_rd); end
      @(negedge clk);
      checks++; if (resp_valid !== 1'b0 || resp_rd !== 5'd4) begin errors++; $display("FAIL sw_pulse got v=%b rd=%0d exp v=0 rd=4", resp_valid, resp_rd); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_d [3];
      exp_d[0] = 32'hFFFFFF80; exp_d[1] = 32'h00000080; exp_d[2] = 32'hFFFF80FF;
      @(negedge clk);
      drive(1'b1, F3_W, 32'h10, 32'h80FF1234, 5'd0);
      ref_store(F3_W, 32'h10, 32'h80FF1234);
      @(negedge clk); drive(1'b0, F3_B, 32'h13, 32'h0, 5'd1);
      @(negedge clk); drive(1'b0, F3_BU, 32'h13, 32'h0, 5'd2);
      checks++; if (resp_valid !== 1'b1 || resp_data !== exp_d[0] || resp_rd !== 5'd1) begin errors++; $display("FAIL lb got v=%b d=%h rd=%0d exp v=1 d=%h rd=1", resp_valid, resp_data, resp_rd, exp_d[0]); end
      @(negedge clk); drive(1'b0, F3_H, 32'h12, 32'h0, 5'd3);
      checks++; if (resp_valid !== 1'b1 || resp_data !== exp_d[1] || resp_rd !== 5'd2) begin errors++; $display("FAIL lbu got v=%b d=%h rd=%0d exp v=1 d=%h rd=2", resp_valid, resp_data, resp_rd, exp_d[1]); end
      @(negedge clk); req_valid = 1'b0;
      checks++; if (resp_valid !== 1'b1 || resp_data !== exp_d[2] || resp_rd !== 5'd3) begin errors++; $display("FAIL lh got v=%b d=%h rd=%0d exp v=1 d=%h rd=3", resp_valid, resp_data, resp_rd, exp_d[2]); end
      @(negedge clk);
      checks++; if (resp_valid !== 1'b0 || resp_data !== exp_d[2]) begin errors++; $display("FAIL lh_hold got v=%b d=%h exp v=0 d=%h", resp_valid, resp_data, exp_d[2]); end
   endtask

   task automatic test_split_load();
      @(negedge clk); drive(1'b1, F3_W, 32'h10, 32'hAABBCCDD, 5'd0); ref_store(F3_W, 32'h10, 32'hAABBCCDD);
      @(negedge clk); drive(1'b1, F3_W, 32'h14, 32'h11223344, 5'd0); ref_store(F3_W, 32'h14, 32'h11223344);
      @(negedge clk); drive(1'b0, F3_HU, 32'h13, 32'h0, 5'd7);
      #1;
      checks++; if (dm_addr !== 32'h10 || dm_we !== 1'b0) begin errors++; $display("FAIL lhu_first got a=%h we=%b exp a=10 we=0", dm_addr, dm_we); end
      @(negedge clk); req_valid = 1'b0;
      checks++; if (req_ready !== 1'b0 || resp_valid !== 1'b0 || dm_addr !== 32'h14) begin errors++; $display("FAIL lhu_second got rdy=%b v=%b a=%h exp rdy=0 v=0 a=14", req_ready, resp_valid, dm_addr); end
      @(negedge clk);
      checks++; if (resp_valid !== 1'b1 || resp_data !== 32'h000044AA || resp_rd !== 5'd7 || req_ready !== 1'b1) begin errors++; $display("FAIL lhu_resp got v=%b d=%h rd=%0d rdy=%b exp v=1 d=000044aa rd=7 rdy=1", resp_valid, resp_data, resp_rd, req_ready); end
   endtask

   task automatic test_split_store();
      logic [31:0] exp_w;
      @(negedge clk); drive(1'b1, F3_W, 32'h0E, 32'h01234567, 5'd0); ref_store(F3_W, 32'h0E, 32'h01234567);
      #1;
      checks++; if (dm_addr !== 32'h0C || dm_be !== 4'b1100 || dm_wd !== 32'h45670000 || dm_we !== 1'b1) begin errors++; $display("FAIL ssw_first got a=%h be=%b wd=%h we=%b exp a=0c be=1100 wd=45670000 we=1", dm_addr, dm_be, dm_wd, dm_we); end
      @(negedge clk); req_valid = 1'b0;
      checks++; if (dm_addr !== 32'h10 || dm_be !== 4'b0011 || dm_wd !== 32'h00000123 || dm_we !== 1'b1) begin errors++; $display("FAIL ssw_second got a=%h be=%b wd=%h we=%b exp a=10 be=0011 wd=00000123 we=1", dm_addr, dm_be, dm_wd, dm_we); end
      @(negedge clk);
      checks++; if (resp_valid !== 1'b1 || resp_data !== 32'h0) begin errors++; $display("FAIL ssw_resp got v=%b d=%h exp v=1 d=0", resp_valid, resp_data); end
      drive(1'b0, F3_W, 32'h0C, 32'h0, 5'd5);
      exp_w = ref_load(F3_W, 32'h0C);
      @(negedge clk); drive(1'b0, F3_W, 32'h10, 32'h0, 5'd6);
      checks++; if (resp_data !== exp_w || resp_data[31:16] !== 16'h4567) begin errors++; $display("FAIL ssw_rb0c got=%h exp=%h", resp_data, exp_w); end
      exp_w = ref_load(F3_W, 32'h10);
      @(negedge clk); req_valid = 1'b0;
      checks++; if (resp_data !== exp_w || resp_data[15:0] !== 16'h0123) begin errors++; $display("FAIL ssw_rb10 got=%h exp=%h", resp_data, exp_w); end
   endtask

   task automatic test_fault();
      logic [31:0] exp_w;
      exp_w = ref_load(F3_W, 32'h02);
      @(negedge clk); drive(1'b0, F3_W, 32'h02, 32'h0, 5'd9);
      #1;
      checks++; if (dm_we0 !== 1'b0) begin errors++; $display("FAIL strict_lw_we got=%b exp=0", dm_we0); end
      @(negedge clk); req_valid = 1'b0;
      checks++; if (resp_valid0 !== 1'b1 || resp_fault0 !== 1'b1 || resp_data0 !== 32'h0 || resp_rd0 !== 5'd9) begin errors++; $display("FAIL strict_lw_resp got v=%b f=%b d=%h rd=%0d exp v=1 f=1 d=0 rd=9", resp_valid0, resp_fault0, resp_data0, resp_rd0); end
      @(negedge clk);
      checks++; if (resp_valid !== 1'b1 || resp_fault !== 1'b0 || resp_data !== exp_w) begin errors++; $display("FAIL relaxed_lw got v=%b f=%b d=%h exp v=1 f=0 d=%h", resp_valid, resp_fault, resp_data, exp_w); end
      drive(1'b0, 3'b011, 32'h20, 32'h0, 5'd10);
      @(negedge clk); req_valid = 1'b0;
      checks++; if (resp_valid !== 1'b1 || resp_fault !== 1'b1 || resp_data !== 32'h0 || resp_fault0 !== 1'b1 || resp_data0 !== 32'h0) begin errors++; $display("FAIL ld_f3_011 got f=%b d=%h f0=%b d0=%h exp f=1 d=0", resp_fault, resp_data, resp_fault0, resp_data0); end
      drive(1'b1, F3_BU, 32'h20, 32'hFFFFFFFF, 5'd11);
      #1;
      checks++; if (dm_we !== 1'b0) begin errors++; $display("FAIL st_f3_100_we got=%b exp=0", dm_we); end
      @(negedge clk); req_valid = 1'b0;
      checks++; if (resp_valid !== 1'b1 || resp_fault !== 1'b1 || resp_rd !== 5'd11) begin errors++; $display("FAIL st_f3_100 got v=%b f=%b rd=%0d exp v=1 f=1 rd=11", resp_valid, resp_fault, resp_rd); end
   endtask

   task automatic test_wrap();
      logic [31:0] exp_w;
      @(negedge clk); drive(1'b1, F3_W, 32'hFFFFFFFE, 32'hCAFEF00D, 5'd0); ref_store(F3_W, 32'hFFFFFFFE, 32'hCAFEF00D);
      #1;
      checks++; if (dm_addr !== 32'hFFFFFFFC || dm_be !== 4'b1100) begin errors++; $display("FAIL wrap_first got a=%h be=%b exp a=fffffffc be=1100", dm_addr, dm_be); end
      @(negedge clk); req_valid = 1'b0;
      checks++; if (dm_addr !== 32'h0 || dm_be !== 4'b0011 || dm_wd !== 32'h0000CAFE) begin errors++; $display("FAIL wrap_second got a=%h be=%b wd=%h exp a=0 be=0011 wd=0000cafe", dm_addr, dm_be, dm_wd); end
      @(negedge clk);
      drive(1'b0, F3_W, 32'hFFFFFFFE, 32'h0, 5'd12);
      exp_w = ref_load(F3_W, 32'hFFFFFFFE);
      @(negedge clk); req_valid = 1'b0;
      @(negedge clk);
      checks++; if (resp_valid !== 1'b1 || resp_data !== exp_w || exp_w !== 32'hCAFEF00D) begin errors++; $display("FAIL wrap_load got v=%b d=%h exp v=1 d=%h", resp_valid, resp_data, exp_w); end
   endtask

   task automatic test_reset_mid_split();
      bit saw;
      logic [31:0] exp_w;
      @(negedge clk); drive(1'b1, F3_W, 32'h2E, 32'h55AA33CC, 5'd13);
      ref_mem[8'h2E] = 8'hCC;
      ref_mem[8'h2F] = 8'h33;
      @(negedge clk); req_valid = 1'b0;
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL mid_split_state got rdy=%b exp=0", req_ready); end
      rst_n = 1'b0;
      #1;
      checks++; if (dm_we !== 1'b0) begin errors++; $display("FAIL mid_split_we got=%b exp=0", dm_we); end
      saw = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      repeat (2) begin
         @(negedge clk);
         if (resp_valid) saw = 1'b1;
      end
      checks++; if (saw !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL mid_split_after got resp_seen=%b rdy=%b exp 0/1", saw, req_ready); end
      drive(1'b0, F3_W, 32'h2C, 32'h0, 5'd14);
      exp_w = ref_load(F3_W, 32'h2C);
      @(negedge clk); drive(1'b0, F3_W, 32'h30, 32'h0, 5'd15);
      checks++; if (resp_data !== exp_w || resp_data[31:16] !== 16'h33CC) begin errors++; $display("FAIL mid_split_lo got=%h exp=%h", resp_data, exp_w); end
      exp_w = ref_load(F3_W, 32'h30);
      @(negedge clk); req_valid = 1'b0;
      checks++; if (resp_data !== exp_w) begin errors++; $display("FAIL mid_split_hi got=%h exp=%h", resp_data, exp_w); end
   endtask

   task automatic test_random();
      bit          we, exp_fault, exp_split;
      logic [2:0]  f3;
      logic [31:0] a, wd, exp_d;
      logic [4:0]  rd;
      int          lat;
      for (int n = 0; n < 200; n++) begin
         we = 1'($urandom_range(0, 2) == 0);
         case ($urandom_range(0, 5))
            0:       f3 = F3_B;
            1:       f3 = F3_H;
            2:       f3 = F3_W;
            3:       f3 = F3_BU;
            4:       f3 = F3_HU;
            default: f3 = 3'($urandom_range(0, 7));
         endcase
         a  = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'($urandom_range(0, 47));
         wd = 32'($urandom);
         rd = 5'($urandom);
         exp_fault = is_fault(we, f3, a, 1'b1);
         exp_split = is_split(we, f3, a);
         exp_d     = (we || exp_fault) ? 32'h0 : ref_load(f3, a);
         if (we && !exp_fault) ref_store(f3, a, wd);
         @(negedge clk); drive(we, f3, a, wd, rd);
         @(negedge clk); req_valid = 1'b0;
         lat = 1;
         while (!resp_valid && lat < 4) begin
            @(negedge clk);
            lat++;
         end
         checks++;
         if (resp_valid !== 1'b1 || lat != (exp_split ? 2 : 1) || resp_fault !== exp_fault ||
             resp_data !== exp_d || resp_rd !== rd) begin
            errors++;
            $display("FAIL rnd#%0d we=%b f3=%0d a=%h got v=%b lat=%0d f=%b d=%h rd=%0d exp lat=%0d f=%b d=%h rd=%0d",
                     n, we, f3, a, resp_valid, lat, resp_fault, resp_data, resp_rd,
                     exp_split ? 2 : 1, exp_fault, exp_d, rd);
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_store_word();
      test_back_to_back();
      test_split_load();
      test_split_store();
      test_fault();
      test_wrap();
      test_reset_mid_split();
      test_random();
      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
